// File: rtl/round_sequencer_if.sv
// Signal bundle shared by game_playing, the gameplay datapath and round_sequencer.
interface round_sequencer_if;
    logic       startGameNow;
    logic       gamePlaying;
    logic       playerHit;
    logic       levelCleared;
    logic       freeze;
    logic       roundReset;
    logic [1:0] countdown;
    logic [6:0] timeLeft;
    logic [1:0] lives;
    logic [1:0] level;
    logic       GameOver;
    logic       GameWonOut;

    modport master (
        output startGameNow, gamePlaying, playerHit, levelCleared,
        input  freeze, roundReset, countdown, timeLeft, lives, level, GameOver, GameWonOut
    );

    modport slave (
        input  startGameNow, gamePlaying, playerHit, levelCleared,
        output freeze, roundReset, countdown, timeLeft, lives, level, GameOver, GameWonOut
    );
endinterface

// File: rtl/round_sequencer.sv
// Session sequencer: countdown, round timer, lives/level bookkeeping and hit/level-up pauses.
module round_sequencer #(
    parameter int TICKS_PER_SEC  = 50000000,
    parameter int COUNTDOWN_SECS = 3,
    parameter int ROUND_SECS     = 60,
    parameter int PAUSE_SECS     = 1,
    parameter int NUM_LIVES      = 3,
    parameter int NUM_LEVELS     = 4
) (
    input logic              CLOCK_50,
    input logic              reset_n,
    round_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        COUNTDOWN = 3'd1,
        PLAY      = 3'd2,
        PAUSE     = 3'd3,
        FINISH    = 3'd4
    } state_t;

    localparam int PSW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int PW  = (PAUSE_SECS > 1) ? $clog2(PAUSE_SECS) : 1;
    localparam logic [PSW-1:0] PRESCALE_LAST = PSW'(TICKS_PER_SEC - 1);
    localparam logic [PW-1:0]  PAUSE_LAST    = PW'(PAUSE_SECS - 1);
    localparam logic [1:0]     COUNT_INIT    = 2'(COUNTDOWN_SECS);
    localparam logic [6:0]     ROUND_INIT    = 7'(ROUND_SECS);
    localparam logic [1:0]     LIVES_INIT    = 2'(NUM_LIVES);
    localparam logic [1:0]     LAST_LEVEL    = 2'(NUM_LEVELS - 1);

    state_t         state_r, state_s;
    logic [PSW-1:0] prescaler_r, prescaler_s;
    logic [PW-1:0]  pauseCnt_r, pauseCnt_s;
    logic           levelUp_r, levelUp_s;
    logic           freeze_r, freeze_s;
    logic           roundReset_r, roundReset_s;
    logic [1:0]     countdown_r, countdown_s;
    logic [6:0]     timeLeft_r, timeLeft_s;
    logic [1:0]     lives_r, lives_s;
    logic [1:0]     level_r, level_s;
    logic           gameOver_r, gameOver_s;
    logic           gameWon_r, gameWon_s;
    logic           secTick_s;

    assign secTick_s = (prescaler_r == PRESCALE_LAST);

    // Next-state and next-output logic; abort from gamePlaying outranks every in-game event.
    always_comb begin
        state_s      = state_r;
        pauseCnt_s   = pauseCnt_r;
        levelUp_s    = levelUp_r;
        countdown_s  = countdown_r;
        timeLeft_s   = timeLeft_r;
        lives_s      = lives_r;
        level_s      = level_r;
        gameWon_s    = gameWon_r;
        roundReset_s = 1'b0;
        gameOver_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.startGameNow) begin
                    state_s      = COUNTDOWN;
                    lives_s      = LIVES_INIT;
                    level_s      = 2'd0;
                    countdown_s  = COUNT_INIT;
                    timeLeft_s   = ROUND_INIT;
                    gameWon_s    = 1'b0;
                    roundReset_s = 1'b1;
                end else begin
                    state_s = IDLE;
                end
            end
            COUNTDOWN: begin
                if (!bus.gamePlaying) begin
                    state_s = IDLE;
                end else if (secTick_s) begin
                    if (countdown_r <= 2'd1) begin
                        countdown_s = 2'd0;
                        state_s     = PLAY;
                    end else begin
                        countdown_s = countdown_r - 2'd1;
                    end
                end else begin
                    state_s = COUNTDOWN;
                end
            end
            PLAY: begin
                if (!bus.gamePlaying) begin
                    state_s = IDLE;
                end else if (bus.levelCleared) begin
                    if (level_r == LAST_LEVEL) begin
                        state_s    = FINISH;
                        gameOver_s = 1'b1;
                        gameWon_s  = 1'b1;
                    end else begin
                        state_s    = PAUSE;
                        levelUp_s  = 1'b1;
                        pauseCnt_s = {PW{1'b0}};
                    end
                end else if (bus.playerHit) begin
                    if (lives_r <= 2'd1) begin
                        lives_s    = 2'd0;
                        state_s    = FINISH;
                        gameOver_s = 1'b1;
                        gameWon_s  = 1'b0;
                    end else begin
                        lives_s    = lives_r - 2'd1;
                        state_s    = PAUSE;
                        levelUp_s  = 1'b0;
                        pauseCnt_s = {PW{1'b0}};
                    end
                end else if (secTick_s) begin
                    if (timeLeft_r <= 7'd1) begin
                        timeLeft_s = 7'd0;
                        state_s    = FINISH;
                        gameOver_s = 1'b1;
                        gameWon_s  = 1'b0;
                    end else begin
                        timeLeft_s = timeLeft_r - 7'd1;
                    end
                end else begin
                    state_s = PLAY;
                end
            end
            PAUSE: begin
                if (!bus.gamePlaying) begin
                    state_s = IDLE;
                end else if (secTick_s) begin
                    if (pauseCnt_r == PAUSE_LAST) begin
                        if (levelUp_r) begin
                            level_s = level_r + 2'd1;
                        end else begin
                            level_s = level_r;
                        end
                        timeLeft_s   = ROUND_INIT;
                        countdown_s  = COUNT_INIT;
                        roundReset_s = 1'b1;
                        state_s      = COUNTDOWN;
                    end else begin
                        pauseCnt_s = pauseCnt_r + PW'(1'b1);
                    end
                end else begin
                    state_s = PAUSE;
                end
            end
            FINISH: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        // Every state change restarts the second so each state gets a full first second.
        if ((state_s != state_r) || secTick_s) begin
            prescaler_s = {PSW{1'b0}};
        end else begin
            prescaler_s = prescaler_r + PSW'(1'b1);
        end
        freeze_s = (state_s != PLAY);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge CLOCK_50) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            prescaler_r  <= {PSW{1'b0}};
            pauseCnt_r   <= {PW{1'b0}};
            levelUp_r    <= 1'b0;
            freeze_r     <= 1'b1;
            roundReset_r <= 1'b0;
            countdown_r  <= 2'd0;
            timeLeft_r   <= 7'd0;
            lives_r      <= 2'd0;
            level_r      <= 2'd0;
            gameOver_r   <= 1'b0;
            gameWon_r    <= 1'b0;
        end else begin
            state_r      <= state_s;
            prescaler_r  <= prescaler_s;
            pauseCnt_r   <= pauseCnt_s;
            levelUp_r    <= levelUp_s;
            freeze_r     <= freeze_s;
            roundReset_r <= roundReset_s;
            countdown_r  <= countdown_s;
            timeLeft_r   <= timeLeft_s;
            lives_r      <= lives_s;
            level_r      <= level_s;
            gameOver_r   <= gameOver_s;
            gameWon_r    <= gameWon_s;
        end
    end

    assign bus.freeze     = freeze_r;
    assign bus.roundReset = roundReset_r;
    assign bus.countdown  = countdown_r;
    assign bus.timeLeft   = timeLeft_r;
    assign bus.lives      = lives_r;
    assign bus.level      = level_r;
    assign bus.GameOver   = gameOver_r;
    assign bus.GameWonOut = gameWon_r;
endmodule

// File: tb/tb_round_sequencer.sv
// Directed plus randomized bench for round_sequencer against a seconds-based reference model.
module tb_round_sequencer;
    localparam int T   = 4;
    localparam int CS  = 3;
    localparam int RS  = 2;
    localparam int PS  = 1;
    localparam int NL  = 3;
    localparam int NLV = 2;

    localparam int P_IDLE  = 0;
    localparam int P_CD    = 1;
    localparam int P_PLAY  = 2;
    localparam int P_PAUSE = 3;
    localparam int P_FIN   = 4;

    logic CLOCK_50;
    logic reset_n;
    round_sequencer_if bus ();

    round_sequencer #(
        .TICKS_PER_SEC (T),
        .COUNTDOWN_SECS(CS),
        .ROUND_SECS    (RS),
        .PAUSE_SECS    (PS),
        .NUM_LIVES     (NL),
        .NUM_LEVELS    (NLV)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    int nAsserts = 0;
    int nFails   = 0;

    // Reference model: phase plus cycles spent in it; displays derived from elapsed seconds.
    int mPhase = P_IDLE;
    int mK     = 0;
    int mCd    = 0;
    int mTl    = 0;
    int mLives = 0;
    int mLevel = 0;
    int mWon   = 0;
    int mRr    = 0;
    int mGo    = 0;
    int mLvUp  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        int nxt;
        if (reset_n === 1'b0) begin
            mPhase = P_IDLE; mK = 0; mCd = 0; mTl = 0; mLives = 0;
            mLevel = 0; mWon = 0; mRr = 0; mGo = 0; mLvUp = 0;
            return;
        end
        mRr = 0;
        mGo = 0;
        nxt = mPhase;
        case (mPhase)
            P_IDLE: if (bus.startGameNow) begin
                nxt = P_CD; mLives = NL; mLevel = 0; mCd = CS; mTl = RS; mWon = 0; mRr = 1;
            end
            P_CD: if (!bus.gamePlaying) nxt = P_IDLE;
                  else if (mK + 1 == CS * T) begin nxt = P_PLAY; mCd = 0; end
                  else mCd = CS - (mK + 1) / T;
            P_PLAY: if (!bus.gamePlaying) nxt = P_IDLE;
                else if (bus.levelCleared) begin
                    if (mLevel == NLV - 1) begin nxt = P_FIN; mWon = 1; mGo = 1; end
                    else begin nxt = P_PAUSE; mLvUp = 1; end
                end else if (bus.playerHit) begin
                    if (mLives == 1) begin mLives = 0; nxt = P_FIN; mWon = 0; mGo = 1; end
                    else begin mLives = mLives - 1; nxt = P_PAUSE; mLvUp = 0; end
                end else if (mK + 1 == RS * T) begin mTl = 0; nxt = P_FIN; mWon = 0; mGo = 1; end
                else mTl = RS - (mK + 1) / T;
            P_PAUSE: if (!bus.gamePlaying) nxt = P_IDLE;
                else if (mK + 1 == PS * T) begin
                    if (mLvUp != 0) mLevel = mLevel + 1;
                    mTl = RS; mCd = CS; mRr = 1; nxt = P_CD;
                end
            default: nxt = P_IDLE;
        endcase
        mK = (nxt != mPhase) ? 0 : mK + 1;
        mPhase = nxt;
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        model_update();
        #1;
        check("freeze",     32'(bus.freeze),     32'(mPhase != P_PLAY));
        check("roundReset", 32'(bus.roundReset), 32'(mRr));
        check("countdown",  32'(bus.countdown),  32'(mCd));
        check("timeLeft",   32'(bus.timeLeft),   32'(mTl));
        check("lives",      32'(bus.lives),      32'(mLives));
        check("level",      32'(bus.level),      32'(mLevel));
        check("GameOver",   32'(bus.GameOver),   32'(mGo));
        check("GameWonOut", 32'(bus.GameWonOut), 32'(mWon));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_game();
        bus.startGameNow = 1'b1;
        tick();
        bus.startGameNow = 1'b0;
    endtask

    task automatic wait_play(input string tag);
        int k;
        k = 0;
        while (bus.freeze !== 1'b0 && k < 40) begin tick(); k++; end
        check(tag, 32'(bus.freeze), 32'd0);
    endtask

    task automatic wait_round_reset(input string tag, output int cnt);
        cnt = 0;
        while (bus.roundReset !== 1'b1 && cnt < 12) begin tick(); cnt++; end
        check(tag, 32'(bus.roundReset), 32'd1);
    endtask

    initial begin
        int cnt;
        reset_n = 1'b0;
        bus.startGameNow = 1'b0;
        bus.gamePlaying  = 1'b1;
        bus.playerHit    = 1'b0;
        bus.levelCleared = 1'b0;
        run(2);
        check("reset_freeze", 32'(bus.freeze), 32'd1);
        reset_n = 1'b1;
        run(2);

        // Countdown timing from the start pulse.
        start_game();
        check("start_roundReset", 32'(bus.roundReset), 32'd1);
        check("start_countdown", 32'(bus.countdown), 32'd3);
        run(4);
        check("countdown_2", 32'(bus.countdown), 32'd2);
        run(4);
        check("countdown_1", 32'(bus.countdown), 32'd1);
        run(3);
        check("still_frozen", 32'(bus.freeze), 32'd1);
        tick();
        check("play_at_13", 32'(bus.freeze), 32'd0);

        // Three hits, each after the previous pause completes.
        for (int i = 0; i < 3; i++) begin
            run($urandom_range(0, 5));
            bus.playerHit = 1'b1;
            tick();
            bus.playerHit = 1'b0;
            check("hit_lives", 32'(bus.lives), 32'(NL - 1 - i));
            if (i < 2) wait_play("hit_replay");
        end
        check("lose_GameOver", 32'(bus.GameOver), 32'd1);
        check("lose_won", 32'(bus.GameWonOut), 32'd0);
        tick();
        check("lose_GameOver_off", 32'(bus.GameOver), 32'd0);
        tick();
        check("lose_won_hold", 32'(bus.GameWonOut), 32'd0);

        // Level clear, pause length, then win.
        start_game();
        wait_play("lvl_play");
        run($urandom_range(0, 5));
        bus.levelCleared = 1'b1;
        tick();
        bus.levelCleared = 1'b0;
        wait_round_reset("lvl_rr", cnt);
        check("pause_len", 32'(cnt), 32'd4);
        check("lvl_level", 32'(bus.level), 32'd1);
        wait_play("lvl_play2");
        bus.levelCleared = 1'b1;
        tick();
        bus.levelCleared = 1'b0;
        check("win_GameOver", 32'(bus.GameOver), 32'd1);
        check("win_won", 32'(bus.GameWonOut), 32'd1);
        run(4);
        check("win_hold", 32'(bus.GameWonOut), 32'd1);
        start_game();
        check("win_cleared", 32'(bus.GameWonOut), 32'd0);

        // Round timer runs out.
        wait_play("to_play");
        check("to_tl2", 32'(bus.timeLeft), 32'd2);
        run(4);
        check("to_tl1", 32'(bus.timeLeft), 32'd1);
        run(4);
        check("to_tl0", 32'(bus.timeLeft), 32'd0);
        check("to_GameOver", 32'(bus.GameOver), 32'd1);
        check("to_won", 32'(bus.GameWonOut), 32'd0);
        tick();

        // Coincident hit and level clear: level clear wins.
        start_game();
        wait_play("co_play");
        run($urandom_range(0, 3));
        bus.playerHit = 1'b1;
        bus.levelCleared = 1'b1;
        tick();
        bus.playerHit = 1'b0;
        bus.levelCleared = 1'b0;
        check("co_lives", 32'(bus.lives), 32'(NL));
        wait_round_reset("co_rr", cnt);
        check("co_level", 32'(bus.level), 32'd1);

        // Reset mid-PLAY.
        wait_play("rst_play");
        run(2);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("rst_freeze", 32'(bus.freeze), 32'd1);
        check("rst_lives", 32'(bus.lives), 32'd0);
        check("rst_level", 32'(bus.level), 32'd0);

        // gamePlaying dropped mid-PLAY aborts without a GameOver pulse.
        start_game();
        wait_play("ab_play");
        tick();
        bus.gamePlaying = 1'b0;
        tick();
        bus.gamePlaying = 1'b1;
        check("ab_freeze", 32'(bus.freeze), 32'd1);
        check("ab_GameOver", 32'(bus.GameOver), 32'd0);
        tick();
        check("ab_GameOver2", 32'(bus.GameOver), 32'd0);
        check("ab_lives_kept", 32'(bus.lives), 32'(NL));

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bus.startGameNow = ($urandom_range(0, 15) == 0);
            bus.gamePlaying  = ($urandom_range(0, 29) != 0);
            bus.playerHit    = ($urandom_range(0, 9) == 0);
            bus.levelCleared = ($urandom_range(0, 13) == 0);
            reset_n          = ($urandom_range(0, 149) != 0);
            tick();
        end
        bus.startGameNow = 1'b0;
        bus.playerHit    = 1'b0;
        bus.levelCleared = 1'b0;
        reset_n          = 1'b1;
        run(2);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end
endmodule
